// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, req/ack instruction memory port,
// freeze skid buffer and branch redirect with discard of in-flight stale fetches.
//
// state   | meaning
// FETCH   | request at pc; accept, skid or bubble depending on ack/freeze/branch
// HOLD    | acked word parked in skid_instr while frozen; no request issued
// DISCARD | redirected while a request is outstanding; wait for and drop its ack
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_addr, pend_nxt;
    logic [31:0] skid_instr, skid_nxt;
    logic [31:0] pc_out_nxt, instr_nxt;
    logic        valid_nxt;
    logic [31:0] pc_inc;

    assign pc_inc    = pc + 32'd4;
    assign imem_req  = rst && (state != HOLD);
    // The outstanding address stays on the bus even though pc already moved to the target.
    assign imem_addr = (state == DISCARD) ? pend_addr : pc;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pend_nxt   = pend_addr;
        skid_nxt   = skid_instr;
        pc_out_nxt = pc_out;
        instr_nxt  = instruction_out;
        valid_nxt  = valid_out;
        case (state)
            FETCH: begin
                if (branch_taken) begin
                    pc_nxt     = branch_addr;
                    pc_out_nxt = 32'd0;
                    instr_nxt  = NOP_INSTR;
                    valid_nxt  = 1'b0;
                    if (!imem_ack) begin
                        state_nxt = DISCARD;
                        pend_nxt  = pc;
                    end
                end else if (imem_ack && !freeze) begin
                    pc_out_nxt = pc_inc;
                    instr_nxt  = imem_rdata;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc_inc;
                end else if (imem_ack) begin
                    skid_nxt  = imem_rdata;
                    state_nxt = HOLD;
                end else if (!freeze) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_nxt     = branch_addr;
                    pc_out_nxt = 32'd0;
                    instr_nxt  = NOP_INSTR;
                    valid_nxt  = 1'b0;
                    skid_nxt   = 32'd0;
                    state_nxt  = FETCH;
                end else if (!freeze) begin
                    pc_out_nxt = pc_inc;
                    instr_nxt  = skid_instr;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc_inc;
                    state_nxt  = FETCH;
                end
            end
            DISCARD: begin
                if (branch_taken) begin
                    pc_nxt     = branch_addr;
                    pc_out_nxt = 32'd0;
                    instr_nxt  = NOP_INSTR;
                    valid_nxt  = 1'b0;
                end else if (!freeze) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
                if (imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            pend_addr       <= RESET_PC;
            skid_instr      <= 32'd0;
            pc_out          <= 32'd0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            pend_addr       <= pend_nxt;
            skid_instr      <= skid_nxt;
            pc_out          <= pc_out_nxt;
            instruction_out <= instr_nxt;
            valid_out       <= valid_nxt;
        end
    end

endmodule
